wb_select_unit: RTL and testbench
=================================

Name: wb_select_unit

Overview:
Registered writeback-data selector for the multicycle RISC-V datapath; it is the successor to the combinational register-file data mux. It selects among ALU result, load data, constants, PC, PC+step and immediate, and performs load byte/half/word/double extraction with sign or zero extension. It drives a one-shot register-file write strobe with the destination index. Latency is fixed per source class, under a small request/ready handshake controlled by the main FSM.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64.
PC_STEP, 4, increment added to PC for the link source.
OFFW, $clog2(XLEN/8), byte-offset width; derived, not overridable.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
WB_REQ  in  1  writeback request from control FSM; accepted only when WB_READY=1
WB_READY  out  1  unit can accept a request
SELECT  in  3  source: 000 ALU_OUT, 001 load (MEM_DATA_REG), 010 const 1, 011 const 0, 100 PC, 101 PC+PC_STEP, 110 IMM, 111 reserved
ALU_OUT  in  XLEN  ALU result
MEM_DATA_REG  in  XLEN  raw aligned memory word
PC  in  XLEN  current instruction address
IMM  in  XLEN  extended immediate (LUI path)
LOAD_SIZE  in  2  00 byte, 01 half, 10 word, 11 double
LOAD_UNSIGNED  in  1  1 = zero-extend, 0 = sign-extend
BYTE_OFF  in  OFFW  byte offset of load within MEM_DATA_REG
RD_ADDR  in  5  destination register index
WB_DATA  out  XLEN  registered writeback value
WB_RD  out  5  registered destination index
WB_WE  out  1  one-cycle register-file write strobe
WB_ERR  out  1  one-cycle error pulse (reserved select or misaligned load)

Behaviour:
- Reset (sync, high): state IDLE; WB_DATA=0, WB_RD=0, WB_WE=0, WB_ERR=0, WB_READY=1. Reset overrides any in-flight request; a pending ALIGN is discarded with no write.
- States: IDLE, ALIGN, WRITE.
- IDLE, WB_REQ=1, SELECT != 001, SELECT != 111:
  - Capture the selected value into WB_DATA and RD_ADDR into WB_RD; go to WRITE.
  - WB_WE=1 in the following cycle. Latency is 1.
- IDLE, WB_REQ=1, SELECT=001:
  - Capture MEM_DATA_REG, LOAD_SIZE, LOAD_UNSIGNED, BYTE_OFF and RD_ADDR; go to ALIGN; WB_READY=0.
  - ALIGN: shifted = captured data >> (8*BYTE_OFF); keep low 8/16/32/64 bits; extend to XLEN.
  - ALIGN then loads WB_DATA and goes to WRITE. WB_WE=1 two cycles after acceptance.
- WRITE: WB_WE=1 for exactly one cycle; return to IDLE. WB_READY=0 in ALIGN and WRITE.
- WB_REQ while WB_READY=0 is ignored; it is not queued.
- Misaligned load (BYTE_OFF not a multiple of the size in bytes):
  - Detected at acceptance; WB_ERR pulses the next cycle; no WB_WE; WB_DATA and WB_RD hold; return to IDLE.
- SELECT=111: WB_ERR pulses the next cycle; no write; outputs hold; stays IDLE.
- XLEN=32 with LOAD_SIZE=11: treated as misaligned/illegal, same error handling.
- RD_ADDR=0: data path unchanged, but WB_WE is suppressed (x0 is never written). WB_RD still updates.
- PC+PC_STEP and all arithmetic wrap modulo 2^XLEN. Constants 1 and 0 are zero-extended to XLEN.
- WB_DATA and WB_RD hold their last values when no write occurs. No latches: every SELECT encoding is fully decoded.

Test Plan:
- XLEN=64; reset mid-ALIGN (load accepted, reset the next cycle) -> no WB_WE, WB_DATA=0, WB_READY=1 after reset.
- SELECT=000, ALU_OUT=0x1234, RD_ADDR=5, WB_REQ pulse -> next cycle WB_WE=1, WB_DATA=0x1234, WB_RD=5; then WB_WE=0.
- SELECT=001, MEM_DATA_REG=0x00000000_80FF_0000, LOAD_SIZE=00, BYTE_OFF=2, signed -> WB_WE two cycles later, WB_DATA=0xFFFF_FFFF_FFFF_FFFF. Same with LOAD_UNSIGNED=1 -> 0xFF. Half at BYTE_OFF=2, signed -> 0xFFFF_FFFF_FFFF_80FF.
- SELECT=001, LOAD_SIZE=10, BYTE_OFF=2 -> WB_ERR pulse, no WB_WE, WB_DATA unchanged.
- SELECT=101, PC=0xFFFF_FFFF_FFFF_FFFC -> WB_DATA=0x0 (wrap). SELECT=111 -> WB_ERR pulse only.
- SELECT=010, RD_ADDR=0 -> WB_DATA=1, WB_WE stays 0. WB_REQ asserted during ALIGN -> ignored, exactly one write observed.

Source files
------------

// File: rtl/wb_select_unit.sv
// rtl/wb_select_unit.sv - registered writeback selector with load extraction and one-shot RF write strobe
module wb_select_unit #(
    parameter  int XLEN    = 64,
    parameter  int PC_STEP = 4,
    localparam int OFFW    = $clog2(XLEN/8)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            WB_REQ,
    output logic            WB_READY,
    input  logic [2:0]      SELECT,
    input  logic [XLEN-1:0] ALU_OUT,
    input  logic [XLEN-1:0] MEM_DATA_REG,
    input  logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] IMM,
    input  logic [1:0]      LOAD_SIZE,
    input  logic            LOAD_UNSIGNED,
    input  logic [OFFW-1:0] BYTE_OFF,
    input  logic [4:0]      RD_ADDR,
    output logic [XLEN-1:0] WB_DATA,
    output logic [4:0]      WB_RD,
    output logic            WB_WE,
    output logic            WB_ERR
);

    typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_WRITE} state_t;

    state_t            r_state, w_next;
    logic [XLEN-1:0]   r_wb_data;
    logic [4:0]        r_wb_rd;
    logic              r_err;
    logic [XLEN-1:0]   r_ld_data;
    logic [1:0]        r_ld_size;
    logic              r_ld_uns;
    logic [OFFW-1:0]   r_ld_off;
    logic [4:0]        r_ld_rd;

    logic              w_accept, w_is_load, w_is_rsv, w_misalign;
    logic [XLEN-1:0]   w_sel_data, w_shift, w_mask, w_ext;
    logic              w_sign;

    assign w_accept  = WB_REQ && (r_state == S_IDLE);
    assign w_is_load = (SELECT == 3'b001);
    assign w_is_rsv  = (SELECT == 3'b111);

    // Natural alignment only; a double load does not exist on a 32-bit datapath.
    always_comb begin
        case (LOAD_SIZE)
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = BYTE_OFF[0];
            2'b10:   w_misalign = |BYTE_OFF[1:0];
            default: w_misalign = (XLEN == 32) || (|BYTE_OFF);
        endcase
    end

    always_comb begin
        case (SELECT)
            3'b000:  w_sel_data = ALU_OUT;
            3'b010:  w_sel_data = XLEN'(1);
            3'b011:  w_sel_data = '0;
            3'b100:  w_sel_data = PC;
            3'b101:  w_sel_data = PC + XLEN'(PC_STEP);
            3'b110:  w_sel_data = IMM;
            default: w_sel_data = '0;
        endcase
    end

    assign w_shift = r_ld_data >> {r_ld_off, 3'b000};

    always_comb begin
        w_mask = '1;
        w_sign = w_shift[XLEN-1];
        case (r_ld_size)
            2'b00: begin
                w_mask = XLEN'(8'hFF);
                w_sign = w_shift[7];
            end
            2'b01: begin
                w_mask = XLEN'(16'hFFFF);
                w_sign = w_shift[15];
            end
            2'b10: begin
                w_mask = XLEN'(32'hFFFF_FFFF);
                w_sign = w_shift[31];
            end
            default: ;
        endcase
        w_ext = (w_shift & w_mask) | ((w_sign && !r_ld_uns) ? ~w_mask : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        WB_READY = 1'b0;
        case (r_state)
            S_IDLE: begin
                WB_READY = 1'b1;
                if (w_accept && !w_is_rsv) begin
                    if (!w_is_load)       w_next = S_WRITE;
                    else if (!w_misalign) w_next = S_ALIGN;
                end
            end
            S_ALIGN: w_next = S_WRITE;
            S_WRITE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_data <= '0;
            r_wb_rd   <= '0;
            r_err     <= 1'b0;
            r_ld_data <= '0;
            r_ld_size <= '0;
            r_ld_uns  <= 1'b0;
            r_ld_off  <= '0;
            r_ld_rd   <= '0;
        end else begin
            r_err <= 1'b0;
            if (w_accept) begin
                if (w_is_rsv || (w_is_load && w_misalign)) begin
                    r_err <= 1'b1;
                end else if (w_is_load) begin
                    r_ld_data <= MEM_DATA_REG;
                    r_ld_size <= LOAD_SIZE;
                    r_ld_uns  <= LOAD_UNSIGNED;
                    r_ld_off  <= BYTE_OFF;
                    r_ld_rd   <= RD_ADDR;
                end else begin
                    r_wb_data <= w_sel_data;
                    r_wb_rd   <= RD_ADDR;
                end
            end
            if (r_state == S_ALIGN) begin
                r_wb_data <= w_ext;
                r_wb_rd   <= r_ld_rd;
            end
        end
    end

    // x0 is hardwired zero, so its write strobe is dropped while data/index still update.
    assign WB_WE   = (r_state == S_WRITE) && (r_wb_rd != 5'd0);
    assign WB_DATA = r_wb_data;
    assign WB_RD   = r_wb_rd;
    assign WB_ERR  = r_err;

endmodule

// File: tb/tb_wb_select_unit.sv
// tb/tb_wb_select_unit.sv - self-checking bench for wb_select_unit with a transaction-level model
module tb_wb_select_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        WB_REQ = 1'b0;
    logic        WB_READY;
    logic [2:0]  SELECT = '0;
    logic [63:0] ALU_OUT = '0, MEM_DATA_REG = '0, PC = '0, IMM = '0;
    logic [1:0]  LOAD_SIZE = '0;
    logic        LOAD_UNSIGNED = 1'b0;
    logic [2:0]  BYTE_OFF = '0;
    logic [4:0]  RD_ADDR = '0;
    logic [63:0] WB_DATA;
    logic [4:0]  WB_RD;
    logic        WB_WE, WB_ERR;

    int n_checks = 0;
    int n_errors = 0;
    int we_count = 0;

    wb_select_unit #(.XLEN(64), .PC_STEP(4)) dut (
        .clk(clk), .reset(reset), .WB_REQ(WB_REQ), .WB_READY(WB_READY),
        .SELECT(SELECT), .ALU_OUT(ALU_OUT), .MEM_DATA_REG(MEM_DATA_REG),
        .PC(PC), .IMM(IMM), .LOAD_SIZE(LOAD_SIZE), .LOAD_UNSIGNED(LOAD_UNSIGNED),
        .BYTE_OFF(BYTE_OFF), .RD_ADDR(RD_ADDR), .WB_DATA(WB_DATA), .WB_RD(WB_RD),
        .WB_WE(WB_WE), .WB_ERR(WB_ERR)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] load_val(input logic [63:0] mem, input logic [1:0] size,
                                             input logic uns, input logic [2:0] off);
        logic [63:0] s;
        s = mem >> (8 * off);
        case (size)
            2'd0:    return uns ? 64'(s[7:0])  : 64'($signed(s[7:0]));
            2'd1:    return uns ? 64'(s[15:0]) : 64'($signed(s[15:0]));
            2'd2:    return uns ? 64'(s[31:0]) : 64'($signed(s[31:0]));
            default: return s;
        endcase
    endfunction

    function automatic logic [63:0] src_val(input logic [2:0] sel);
        case (sel)
            3'd0:    return ALU_OUT;
            3'd2:    return 64'd1;
            3'd4:    return PC;
            3'd5:    return PC + 64'd4;
            3'd6:    return IMM;
            default: return 64'd0;
        endcase
    endfunction

    // Model: a write is scheduled at acceptance and lands 1 (plain) or 2 (load) cycles later;
    // the unit is unavailable for exactly that many cycles.
    logic [63:0] m_data = '0, p_val = '0;
    logic [4:0]  m_rd = '0, p_rd = '0;
    logic        m_we = 1'b0, m_err = 1'b0;
    int          m_busy = 0, m_cnt = 0;
    bit          m_started = 1'b0;

    always @(posedge clk) begin
        m_started = 1'b1;
        if (reset) begin
            m_data = '0; m_rd = '0; m_we = 1'b0; m_err = 1'b0;
            m_busy = 0; m_cnt = 0;
        end else begin
            bit req_ok;
            req_ok = WB_REQ && (m_busy == 0);
            m_we = 1'b0;
            m_err = 1'b0;
            if (m_busy > 0) m_busy--;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_data = p_val; m_rd = p_rd; m_we = (p_rd != 0);
                end
            end
            if (req_ok) begin
                if (SELECT == 3'd7) begin
                    m_err = 1'b1;
                end else if (SELECT == 3'd1) begin
                    if ((int'(BYTE_OFF) % (1 << LOAD_SIZE)) != 0) begin
                        m_err = 1'b1;
                    end else begin
                        p_val = load_val(MEM_DATA_REG, LOAD_SIZE, LOAD_UNSIGNED, BYTE_OFF);
                        p_rd = RD_ADDR; m_cnt = 1; m_busy = 2;
                    end
                end else begin
                    m_data = src_val(SELECT); m_rd = RD_ADDR; m_we = (RD_ADDR != 0);
                    m_busy = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("wb_we", 64'(WB_WE), 64'(m_we));
            chk("wb_err", 64'(WB_ERR), 64'(m_err));
            chk("wb_ready", 64'(WB_READY), 64'(m_busy == 0));
            chk("wb_data", WB_DATA, m_data);
            chk("wb_rd", 64'(WB_RD), 64'(m_rd));
            if (WB_WE === 1'b1) we_count++;
        end
    end

    // Drives one request cycle; returns at the negedge right after the accepting edge.
    task automatic do_req(input logic [2:0] sel, input logic [63:0] val, input logic [63:0] mem,
                          input logic [1:0] size, input logic uns, input logic [2:0] off,
                          input logic [4:0] rd);
        @(negedge clk);
        SELECT = sel; ALU_OUT = val; PC = val; IMM = val; MEM_DATA_REG = mem;
        LOAD_SIZE = size; LOAD_UNSIGNED = uns; BYTE_OFF = off; RD_ADDR = rd;
        WB_REQ = 1'b1;
        @(negedge clk);
        WB_REQ = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  sel;
        logic [63:0] val;
        logic [63:0] mem;
        logic [1:0]  size;
        logic        uns;
        logic [2:0]  off;
        logic [4:0]  rd;
        logic        err;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int wc;
        vecs[0] = '{3'd6, 64'hFFFF_F000_1234_5000, 64'd0, 2'd0, 1'b0, 3'd0, 5'd3, 1'b0, 64'hFFFF_F000_1234_5000};
        vecs[1] = '{3'd4, 64'h8000_0000_0000_0010, 64'd0, 2'd0, 1'b0, 3'd0, 5'd4, 1'b0, 64'h8000_0000_0000_0010};
        vecs[2] = '{3'd3, 64'h5555, 64'd0, 2'd0, 1'b0, 3'd0, 5'd6, 1'b0, 64'd0};
        vecs[3] = '{3'd1, 64'd0, 64'hCAFE_BABE_1234_5678, 2'd2, 1'b1, 3'd4, 5'd8, 1'b0, 64'h0000_0000_CAFE_BABE};
        vecs[4] = '{3'd1, 64'd0, 64'hCAFE_BABE_1234_5678, 2'd2, 1'b0, 3'd4, 5'd8, 1'b0, 64'hFFFF_FFFF_CAFE_BABE};
        vecs[5] = '{3'd1, 64'd0, 64'h1234, 2'd1, 1'b0, 3'd1, 5'd9, 1'b1, 64'hFFFF_FFFF_CAFE_BABE};
        vecs[6] = '{3'd1, 64'd0, 64'h8000_0000_0000_0001, 2'd3, 1'b0, 3'd0, 5'd10, 1'b0, 64'h8000_0000_0000_0001};
        vecs[7] = '{3'd1, 64'd0, 64'h8000_0000_0000_0000, 2'd0, 1'b0, 3'd7, 5'd11, 1'b0, 64'hFFFF_FFFF_FFFF_FF80};

        repeat (3) @(negedge clk);
        chk("reset_ready", 64'(WB_READY), 64'd1);
        chk("reset_data", WB_DATA, 64'd0);
        reset = 1'b0;

        // Reset while a load is in ALIGN: no write may ever appear.
        wc = we_count;
        do_req(3'd1, 64'd0, 64'h00FF, 2'd0, 1'b0, 3'd0, 5'd12);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_align_we", 64'(we_count - wc), 64'd0);
        chk("rst_align_data", WB_DATA, 64'd0);
        chk("rst_align_ready", 64'(WB_READY), 64'd1);

        do_req(3'd0, 64'h1234, 64'd0, 2'd0, 1'b0, 3'd0, 5'd5);
        chk("alu_we", 64'(WB_WE), 64'd1);
        chk("alu_data", WB_DATA, 64'h1234);
        chk("alu_rd", 64'(WB_RD), 64'd5);
        @(negedge clk);
        chk("alu_we_drop", 64'(WB_WE), 64'd0);

        do_req(3'd1, 64'd0, 64'h0000_0000_80FF_0000, 2'd0, 1'b0, 3'd2, 5'd1);
        chk("lb_early_we", 64'(WB_WE), 64'd0);
        @(negedge clk);
        chk("lb_we", 64'(WB_WE), 64'd1);
        chk("lb_data", WB_DATA, 64'hFFFF_FFFF_FFFF_FFFF);
        do_req(3'd1, 64'd0, 64'h0000_0000_80FF_0000, 2'd0, 1'b1, 3'd2, 5'd1);
        @(negedge clk);
        chk("lbu_data", WB_DATA, 64'h0000_0000_0000_00FF);
        do_req(3'd1, 64'd0, 64'h0000_0000_80FF_0000, 2'd1, 1'b0, 3'd2, 5'd1);
        @(negedge clk);
        chk("lh_data", WB_DATA, 64'hFFFF_FFFF_FFFF_80FF);

        do_req(3'd1, 64'd0, 64'h0000_0000_80FF_0000, 2'd2, 1'b0, 3'd2, 5'd2);
        chk("lw_mis_err", 64'(WB_ERR), 64'd1);
        chk("lw_mis_we", 64'(WB_WE), 64'd0);
        chk("lw_mis_data", WB_DATA, 64'hFFFF_FFFF_FFFF_80FF);
        @(negedge clk);

        do_req(3'd5, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 2'd0, 1'b0, 3'd0, 5'd7);
        chk("pc4_wrap", WB_DATA, 64'd0);
        do_req(3'd7, 64'hAAAA, 64'd0, 2'd0, 1'b0, 3'd0, 5'd13);
        chk("rsv_err", 64'(WB_ERR), 64'd1);
        chk("rsv_rd", 64'(WB_RD), 64'd7);
        @(negedge clk);

        do_req(3'd2, 64'd0, 64'd0, 2'd0, 1'b0, 3'd0, 5'd0);
        chk("x0_data", WB_DATA, 64'd1);
        chk("x0_we", 64'(WB_WE), 64'd0);

        // A request raised during ALIGN must be dropped, not queued.
        wc = we_count;
        do_req(3'd1, 64'd0, 64'h0123_4567_89AB_CDEF, 2'd3, 1'b0, 3'd0, 5'd9);
        SELECT = 3'd0; ALU_OUT = 64'hDEAD; RD_ADDR = 5'd14; WB_REQ = 1'b1;
        @(negedge clk);
        WB_REQ = 1'b0;
        chk("busy_ld_data", WB_DATA, 64'h0123_4567_89AB_CDEF);
        repeat (3) @(negedge clk);
        chk("busy_we_count", 64'(we_count - wc), 64'd1);

        foreach (vecs[i]) begin
            do_req(vecs[i].sel, vecs[i].val, vecs[i].mem, vecs[i].size, vecs[i].uns,
                   vecs[i].off, vecs[i].rd);
            if (vecs[i].sel == 3'd1 && !vecs[i].err) @(negedge clk);
            chk($sformatf("vec%0d_err", i), 64'(WB_ERR), 64'(vecs[i].err));
            chk($sformatf("vec%0d_data", i), WB_DATA, vecs[i].exp);
            @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
